// File: rtl/fp_16_to_8_converter.sv
// FP16 (1-5-10) to FP8 E5M2 (1-5-2) narrowing converter, 2-stage valid/ready pipe.
// Round-to-nearest-even, optional overflow saturation, saturating event counters.
module fp_16_to_8_converter #(
  parameter bit SATURATE = 1'b0,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] ovf_cnt,
  output logic [CNT_W-1:0] inexact_cnt,
  output logic [CNT_W-1:0] nan_cnt
);

  typedef enum logic [1:0] {
    CLS_FINITE = 2'd0,
    CLS_INF    = 2'd1,
    CLS_NAN    = 2'd2
  } cls_e;

  logic [4:0] in_exp;
  logic [9:0] in_mant;
  logic       s1_load;
  logic       s2_load;
  logic       out_fire;
  logic [6:0] res7;

  logic       s1_valid_q, s1_valid_d;
  logic       s1_sign_q, s1_sign_d;
  cls_e       s1_cls_q, s1_cls_d;
  logic [6:0] s1_trunc_q, s1_trunc_d;
  logic       s1_inc_q, s1_inc_d;
  logic       s1_inexact_q, s1_inexact_d;

  logic       s2_valid_q, s2_valid_d;
  logic [7:0] s2_data_q, s2_data_d;
  logic       s2_ovf_q, s2_ovf_d;
  logic       s2_inexact_q, s2_inexact_d;
  logic       s2_nan_q, s2_nan_d;

  logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;
  logic [CNT_W-1:0] inexact_cnt_q, inexact_cnt_d;
  logic [CNT_W-1:0] nan_cnt_q, nan_cnt_d;

  assign in_exp    = in_data[14:10];
  assign in_mant   = in_data[9:0];
  assign s2_load   = !s2_valid_q || out_ready;
  assign s1_load   = !s1_valid_q || s2_load;
  assign in_ready  = s1_load;
  assign out_fire  = s2_valid_q && out_ready;
  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign ovf_cnt     = ovf_cnt_q;
  assign inexact_cnt = inexact_cnt_q;
  assign nan_cnt     = nan_cnt_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // Stage 1: classify and split into truncated code plus round decision.
  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_sign_d    = s1_sign_q;
    s1_cls_d     = s1_cls_q;
    s1_trunc_d   = s1_trunc_q;
    s1_inc_d     = s1_inc_q;
    s1_inexact_d = s1_inexact_q;
    if (s1_load) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_sign_d    = in_data[15];
        s1_trunc_d   = {in_exp, in_mant[9:8]};
        s1_inc_d     = in_mant[7] && ((|in_mant[6:0]) || in_mant[8]);
        s1_inexact_d = in_mant[7] || (|in_mant[6:0]);
        if (in_exp == 5'h1F) begin
          s1_cls_d = (in_mant != 10'd0) ? CLS_NAN : CLS_INF;
        end else begin
          s1_cls_d = CLS_FINITE;
        end
      end
    end
  end

  // Stage 2: apply the increment; a carry out of the mantissa lands in the exponent.
  assign res7 = s1_trunc_q + {6'd0, s1_inc_q};

  always_comb begin
    s2_valid_d   = s2_valid_q;
    s2_data_d    = s2_data_q;
    s2_ovf_d     = s2_ovf_q;
    s2_inexact_d = s2_inexact_q;
    s2_nan_d     = s2_nan_q;
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_ovf_d     = 1'b0;
        s2_inexact_d = 1'b0;
        s2_nan_d     = 1'b0;
        case (s1_cls_q)
          CLS_NAN: begin
            s2_data_d = {s1_sign_q, 7'h7F};
            s2_nan_d  = 1'b1;
          end
          CLS_INF: begin
            s2_data_d = {s1_sign_q, 7'h7C};
          end
          default: begin
            if (res7 == 7'h7C) begin
              s2_data_d    = {s1_sign_q, (SATURATE ? 7'h7B : 7'h7C)};
              s2_ovf_d     = 1'b1;
              s2_inexact_d = 1'b1;
            end else begin
              s2_data_d    = {s1_sign_q, res7};
              s2_inexact_d = s1_inexact_q;
            end
          end
        endcase
      end
    end
  end

  // Counters advance only when the flagged word actually leaves; clear wins.
  always_comb begin
    ovf_cnt_d     = ovf_cnt_q;
    inexact_cnt_d = inexact_cnt_q;
    nan_cnt_d     = nan_cnt_q;
    if (cnt_clr) begin
      ovf_cnt_d     = '0;
      inexact_cnt_d = '0;
      nan_cnt_d     = '0;
    end else if (out_fire) begin
      if (s2_ovf_q)     ovf_cnt_d     = sat_inc(ovf_cnt_q);
      if (s2_inexact_q) inexact_cnt_d = sat_inc(inexact_cnt_q);
      if (s2_nan_q)     nan_cnt_d     = sat_inc(nan_cnt_q);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid_q    <= 1'b0;
      s1_sign_q     <= 1'b0;
      s1_cls_q      <= CLS_FINITE;
      s1_trunc_q    <= 7'd0;
      s1_inc_q      <= 1'b0;
      s1_inexact_q  <= 1'b0;
      s2_valid_q    <= 1'b0;
      s2_data_q     <= 8'd0;
      s2_ovf_q      <= 1'b0;
      s2_inexact_q  <= 1'b0;
      s2_nan_q      <= 1'b0;
      ovf_cnt_q     <= '0;
      inexact_cnt_q <= '0;
      nan_cnt_q     <= '0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_sign_q     <= s1_sign_d;
      s1_cls_q      <= s1_cls_d;
      s1_trunc_q    <= s1_trunc_d;
      s1_inc_q      <= s1_inc_d;
      s1_inexact_q  <= s1_inexact_d;
      s2_valid_q    <= s2_valid_d;
      s2_data_q     <= s2_data_d;
      s2_ovf_q      <= s2_ovf_d;
      s2_inexact_q  <= s2_inexact_d;
      s2_nan_q      <= s2_nan_d;
      ovf_cnt_q     <= ovf_cnt_d;
      inexact_cnt_q <= inexact_cnt_d;
      nan_cnt_q     <= nan_cnt_d;
    end
  end

endmodule

// File: tb/tb_fp_16_to_8_converter.sv
// Directed bench: three converter instances (wrap, saturate, 2-bit counters) share stimulus.
module tb_fp_16_to_8_converter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic [15:0] in_data;
  logic        out_ready;
  logic        cnt_clr;

  logic        in_ready_a, in_ready_b, in_ready_c;
  logic        out_valid_a, out_valid_b, out_valid_c;
  logic [7:0]  out_data_a, out_data_b, out_data_c;
  logic [15:0] ovf_a, inex_a, nan_a;
  logic [15:0] ovf_b, inex_b, nan_b;
  logic [1:0]  ovf_c, inex_c, nan_c;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fp_16_to_8_converter #(.SATURATE(1'b0), .CNT_W(16)) dut_a (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a), .cnt_clr(cnt_clr),
    .ovf_cnt(ovf_a), .inexact_cnt(inex_a), .nan_cnt(nan_a));

  fp_16_to_8_converter #(.SATURATE(1'b1), .CNT_W(16)) dut_b (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b), .cnt_clr(cnt_clr),
    .ovf_cnt(ovf_b), .inexact_cnt(inex_b), .nan_cnt(nan_b));

  fp_16_to_8_converter #(.SATURATE(1'b0), .CNT_W(2)) dut_c (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready_c), .in_data(in_data),
    .out_valid(out_valid_c), .out_ready(out_ready), .out_data(out_data_c), .cnt_clr(cnt_clr),
    .ovf_cnt(ovf_c), .inexact_cnt(inex_c), .nan_cnt(nan_c));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One word in, checked two edges later on both the wrapping and saturating instances.
  task automatic applyStimulus(input logic [15:0] word, input logic [7:0] exp_a,
                               input logic [7:0] exp_b);
    in_valid = 1'b1;
    in_data  = word;
    checkOutput($sformatf("in_ready %h", word), {31'd0, in_ready_a}, 32'd1);
    tick();
    in_valid = 1'b0;
    checkOutput($sformatf("early out_valid %h", word), {31'd0, out_valid_a}, 32'd0);
    tick();
    checkOutput($sformatf("out_valid %h", word), {31'd0, out_valid_a}, 32'd1);
    checkOutput($sformatf("data_a %h", word), {24'd0, out_data_a}, {24'd0, exp_a});
    checkOutput($sformatf("data_b %h", word), {24'd0, out_data_b}, {24'd0, exp_b});
  endtask

  task automatic clearCounters();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
  endtask

  task automatic checkCounters(input string tag, input int ovf, input int inex, input int nan);
    checkOutput({tag, " ovf_cnt"}, {16'd0, ovf_a}, ovf);
    checkOutput({tag, " inexact_cnt"}, {16'd0, inex_a}, inex);
    checkOutput({tag, " nan_cnt"}, {16'd0, nan_a}, nan);
  endtask

  initial begin
    rstn      = 1'b0;
    in_valid  = 1'b0;
    in_data   = 16'd0;
    out_ready = 1'b1;
    cnt_clr   = 1'b0;
    #12;
    checkOutput("reset out_valid", {31'd0, out_valid_a}, 32'd0);
    checkOutput("reset out_data", {24'd0, out_data_a}, 32'd0);
    checkOutput("reset in_ready", {31'd0, in_ready_a}, 32'd1);
    checkCounters("reset", 0, 0, 0);
    rstn = 1'b1;
    tick();

    $display("[TB] exact values");
    applyStimulus(16'h3C00, 8'h3C, 8'h3C);
    applyStimulus(16'hC000, 8'hC0, 8'hC0);
    applyStimulus(16'h8000, 8'h80, 8'h80);
    applyStimulus(16'h0000, 8'h00, 8'h00);
    tick();
    checkCounters("exact", 0, 0, 0);

    $display("[TB] round-to-nearest-even ties");
    applyStimulus(16'h3C80, 8'h3C, 8'h3C);
    applyStimulus(16'h3D80, 8'h3E, 8'h3E);
    applyStimulus(16'h3C81, 8'h3D, 8'h3D);
    tick();
    checkCounters("ties", 0, 3, 0);

    $display("[TB] overflow");
    clearCounters();
    checkCounters("clear", 0, 0, 0);
    applyStimulus(16'h7BFF, 8'h7C, 8'h7B);
    tick();
    checkCounters("ovf pos", 1, 1, 0);
    checkOutput("ovf_b pos", {16'd0, ovf_b}, 32'd1);
    applyStimulus(16'hFBFF, 8'hFC, 8'hFB);
    tick();
    checkCounters("ovf neg", 2, 2, 0);

    $display("[TB] specials");
    clearCounters();
    applyStimulus(16'h7E00, 8'h7F, 8'h7F);
    tick();
    checkCounters("nan", 0, 0, 1);
    applyStimulus(16'hFC00, 8'hFC, 8'hFC);
    applyStimulus(16'h0001, 8'h00, 8'h00);
    applyStimulus(16'h03FF, 8'h04, 8'h04);
    tick();
    checkCounters("specials", 0, 2, 1);
    checkOutput("inf no ovf_b", {16'd0, ovf_b}, 32'd0);

    $display("[TB] backpressure");
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h3C00;
    checkOutput("bp in_ready c1", {31'd0, in_ready_a}, 32'd1);
    tick();
    in_data = 16'h4000;
    checkOutput("bp in_ready c2", {31'd0, in_ready_a}, 32'd1);
    tick();
    in_data = 16'h4400;
    checkOutput("bp in_ready c3", {31'd0, in_ready_a}, 32'd0);
    checkOutput("bp out_valid", {31'd0, out_valid_a}, 32'd1);
    checkOutput("bp hold A c3", {24'd0, out_data_a}, 32'h3C);
    tick();
    checkOutput("bp in_ready c4", {31'd0, in_ready_a}, 32'd0);
    checkOutput("bp hold A c4", {24'd0, out_data_a}, 32'h3C);
    tick();
    checkOutput("bp hold A c5", {24'd0, out_data_a}, 32'h3C);
    out_ready = 1'b1;
    #1;
    checkOutput("bp in_ready release", {31'd0, in_ready_a}, 32'd1);
    tick();
    in_data = 16'h4800;
    checkOutput("bp out B", {24'd0, out_data_a}, 32'h40);
    tick();
    in_valid = 1'b0;
    checkOutput("bp out C", {24'd0, out_data_a}, 32'h44);
    checkOutput("bp valid C", {31'd0, out_valid_a}, 32'd1);
    tick();
    checkOutput("bp out D", {24'd0, out_data_a}, 32'h48);
    checkOutput("bp valid D", {31'd0, out_valid_a}, 32'd1);
    tick();
    checkOutput("bp drained", {31'd0, out_valid_a}, 32'd0);

    $display("[TB] counter saturation and clear priority");
    clearCounters();
    in_valid = 1'b1;
    in_data  = 16'h7E00;
    for (int i = 0; i < 5; i++) tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    checkOutput("nan_c saturated", {30'd0, nan_c}, 32'd3);
    checkOutput("nan_a count", {16'd0, nan_a}, 32'd5);
    applyStimulus(16'h7E00, 8'h7F, 8'h7F);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    checkOutput("clr priority c", {30'd0, nan_c}, 32'd0);
    checkOutput("clr priority a", {16'd0, nan_a}, 32'd0);

    $display("[TB] reset with words in flight");
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h3C00;
    tick();
    in_data = 16'h4000;
    tick();
    in_valid = 1'b0;
    checkOutput("pre-reset out_valid", {31'd0, out_valid_a}, 32'd1);
    #1;
    rstn = 1'b0;
    #1;
    checkOutput("async reset out_valid", {31'd0, out_valid_a}, 32'd0);
    checkOutput("async reset in_ready", {31'd0, in_ready_a}, 32'd1);
    #3;
    rstn      = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("flushed word %0d", i), {31'd0, out_valid_a}, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global timeout so a stalled pipe still reaches a verdict.
  initial begin
    #20000;
    $display("[TB] FAIL timeout: observed running expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
